// File: rtl/psw_if.sv
// PSW register port bundle: flag-update/exception controls from the pipeline
// and PSW state returned to the execute stage.
interface psw_if #(
  parameter int DEPTH = 4
) ();
  localparam int DW = $clog2(DEPTH + 1);

  logic          upd_en;
  logic          stall;
  logic [15:0]   psw_in;
  logic [15:0]   psw_msk;
  logic          exc_entry;
  logic [2:0]    new_pri;
  logic          exc_ret;
  logic          wake;
  logic [15:0]   psw;
  logic [15:0]   psw_fwd;
  logic          slp;
  logic [DW-1:0] depth;
  logic          stack_err;

  modport master (
    output upd_en, stall, psw_in, psw_msk, exc_entry, new_pri, exc_ret, wake,
    input  psw, psw_fwd, slp, depth, stack_err
  );

  modport slave (
    input  upd_en, stall, psw_in, psw_msk, exc_entry, new_pri, exc_ret, wake,
    output psw, psw_fwd, slp, depth, stack_err
  );
endinterface

// File: rtl/psw_register.sv
// Architectural PSW register with masked flag merge, wake handling and a
// LIFO shadow stack for single-cycle exception entry/return.
module psw_register #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_PSW = 16'h00E0
) (
  input  logic   clk,
  input  logic   rst_n,
  psw_if.slave   bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [15:0]   RSVD_MASK = 16'h1E00;
  localparam logic [15:0]   SLP_BIT   = 16'h0008;
  localparam logic [15:0]   FLT_BIT   = 16'h0100;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0] DEPTH_NIL = DW'(0);

  logic [15:0]   psw_r;
  logic [DW-1:0] depth_r;
  logic          stack_err_r;
  logic [15:0]   stack_r [DEPTH];

  logic          eff_upd_s;
  logic [15:0]   u_s;
  logic [15:0]   w_s;
  logic [15:0]   next_psw_s;
  logic [DW-1:0] next_depth_s;
  logic          next_err_s;
  logic          push_s;
  logic [AW-1:0] push_idx_s;
  logic [AW-1:0] pop_idx_s;

  function automatic logic [15:0] merge_psw(
    input logic [15:0] cur,
    input logic [15:0] din,
    input logic [15:0] msk
  );
    return ((cur & ~msk) | (din & msk)) & ~RSVD_MASK;
  endfunction

  // Handler PSW: new priority in CUR, interrupted priority saved in PRV.
  function automatic logic [15:0] entry_psw(
    input logic [2:0] pri,
    input logic [2:0] prv
  );
    return {prv, 5'b00000, pri, 5'b00000};
  endfunction

  assign push_idx_s = AW'(depth_r);
  assign pop_idx_s  = AW'(depth_r - DEPTH_ONE);

  // Retiring flag update followed by wake.
  always_comb begin
    eff_upd_s = bus.upd_en & ~bus.stall;
    u_s       = psw_r;
    w_s       = psw_r;
    if (eff_upd_s) begin
      u_s = merge_psw(psw_r, bus.psw_in, bus.psw_msk);
    end else begin
      u_s = psw_r;
    end
    if (bus.wake) begin
      w_s = u_s & ~SLP_BIT;
    end else begin
      w_s = u_s;
    end
  end

  // Next-state selection: entry beats return beats plain update.
  always_comb begin
    next_psw_s   = w_s;
    next_depth_s = depth_r;
    next_err_s   = 1'b0;
    push_s       = 1'b0;
    if (bus.exc_entry) begin
      if (depth_r < DEPTH_MAX) begin
        push_s       = 1'b1;
        next_psw_s   = entry_psw(bus.new_pri, w_s[7:5]);
        next_depth_s = depth_r + DEPTH_ONE;
      end else begin
        next_psw_s = w_s | FLT_BIT;
        next_err_s = 1'b1;
      end
    end else if (bus.exc_ret) begin
      if (depth_r != DEPTH_NIL) begin
        next_psw_s   = stack_r[pop_idx_s];
        next_depth_s = depth_r - DEPTH_ONE;
      end else begin
        next_psw_s = w_s | FLT_BIT;
        next_err_s = 1'b1;
      end
    end else begin
      next_psw_s = w_s;
    end
  end

  // Architectural state; reset overrides everything including entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psw_r       <= RESET_PSW & ~RSVD_MASK;
      depth_r     <= DEPTH_NIL;
      stack_err_r <= 1'b0;
    end else begin
      psw_r       <= next_psw_s;
      depth_r     <= next_depth_s;
      stack_err_r <= next_err_s;
    end
  end

  // Shadow stack storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      stack_r[push_idx_s] <= w_s;
    end else begin
      stack_r[push_idx_s] <= stack_r[push_idx_s];
    end
  end

  assign bus.psw       = psw_r;
  assign bus.psw_fwd   = next_psw_s;
  assign bus.slp       = psw_r[3];
  assign bus.depth     = depth_r;
  assign bus.stack_err = stack_err_r;
endmodule
